fcl_ddr_cmd_arb: RTL and testbench

- Round-robin arbiter that shares one DDR3 MCB command port between NUM_REQ requester engines, for example the frame capture writer and a frame readback reader.
- Each requester presents a complete command (instr, bl, byte_addr) with a level request. The arbiter issues exactly one MCB command per grant and returns a one-cycle acknowledge to the winner.
- It sits between the video/DMA engines and the MCB command FIFO. It also watches for starvation and command-port misuse.

---
 rtl/fcl_ddr_pkg.sv | 38 +++
 rtl/fcl_rr_pick.sv | 33 +++
 rtl/fcl_ddr_cmd_arb.sv | 145 ++++++++++++++
 tb/tb_fcl_ddr_cmd_arb.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcl_ddr_pkg.sv
// Shared DDR3 MCB definitions: command instructions, the command payload
// struct, arbiter state encodings and a ceil(log2) helper for sizing.
package fcl_ddr_pkg;

  // MCB command instructions
  localparam logic [2:0] MCB_WR      = 3'b000;
  localparam logic [2:0] MCB_RD      = 3'b001;
  localparam logic [2:0] MCB_WR_AP   = 3'b010;
  localparam logic [2:0] MCB_RD_AP   = 3'b011;
  localparam logic [2:0] MCB_REFRESH = 3'b100;

  localparam int unsigned INSTR_W = 3;
  localparam int unsigned BL_W    = 6;
  localparam int unsigned ADDR_W  = 30;

  // One complete MCB command as presented by a requester
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [BL_W-1:0]    bl;
    logic [ADDR_W-1:0]  byte_addr;
  } mcb_cmd_t;

  // One-hot arbiter states
  typedef enum logic [2:0] {
    ARB_IDLE  = 3'b001,
    ARB_ISSUE = 3'b010,
    ARB_GAP   = 3'b100
  } arb_state_e;

  // Smallest r with 2**r >= value
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((32'd1 << r) < value)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fcl_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// above rr_ptr (wrapping modulo NUM_REQ) and a valid flag.
//   req       : request vector
//   rr_ptr    : highest-priority index this round
//   win_idx   : winning index (0 when none)
//   win_valid : at least one request asserted
module fcl_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_valid
);

  logic [IDX_W-1:0] cand;

  // Scan from rr_ptr upward; the first hit wins
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      cand = IDX_W'((32'(rr_ptr) + j) % NUM_REQ);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fcl_ddr_cmd_arb.sv
// Round-robin arbiter sharing one DDR3 MCB command port among NUM_REQ
// requesters. One command per grant, IDLE -> ISSUE -> GAP per command.
//   sys_clk/_reset      : clock, async active-low reset
//   req, req_*          : per-requester level request and flattened command
//   ack                 : one-hot pulse coincident with ddr_cmd_en
//   ddr_cmd_*           : MCB command port
//   busy                : arbiter active or MCB command FIFO not empty
//   starve_err          : sticky per-requester wait-limit flag
//   proto_err           : sticky flag, winner dropped req before its ack
module fcl_ddr_cmd_arb
  import fcl_ddr_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned MAX_WAIT = 1024
) (
  input  logic                   sys_clk,
  input  logic                   _reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_instr,
  input  logic [6*NUM_REQ-1:0]   req_bl,
  input  logic [30*NUM_REQ-1:0]  req_byte_addr,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   ddr_cmd_clk,
  output logic                   ddr_cmd_en,
  output logic [2:0]             ddr_cmd_instr,
  output logic [5:0]             ddr_cmd_bl,
  output logic [29:0]            ddr_cmd_byte_addr,
  input  logic                   ddr_cmd_full,
  input  logic                   ddr_cmd_empty,
  output logic                   busy,
  output logic [NUM_REQ-1:0]     starve_err,
  output logic                   proto_err
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? clogb2(NUM_REQ) : 1;
  localparam int unsigned WAIT_W = clogb2(MAX_WAIT) + 1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  mcb_cmd_t         cmd_q, cmd_d;
  logic             proto_q, proto_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  mcb_cmd_t         req_cmd [NUM_REQ];

  // Unflatten requester command buses
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_cmd[g] = '{instr:     req_instr[3*g +: 3],
                          bl:        req_bl[6*g +: 6],
                          byte_addr: req_byte_addr[30*g +: 30]};
  end

  fcl_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .win_idx   (pick_idx),
    .win_valid (pick_valid)
  );

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_idx_d = win_idx_q;
    cmd_d     = cmd_q;
    proto_d   = proto_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid && !ddr_cmd_full) begin
          win_idx_d = pick_idx;
          cmd_d     = req_cmd[pick_idx];
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        rr_ptr_d = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + IDX_W'(1);
        if (!req[win_idx_q]) proto_d = 1'b1;
        state_d = ARB_GAP;
      end
      ARB_GAP:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge _reset) begin
    if (!_reset) begin
      state_q   <= ARB_IDLE;
      rr_ptr_q  <= '0;
      win_idx_q <= '0;
      cmd_q     <= '0;
      proto_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_idx_q <= win_idx_d;
      cmd_q     <= cmd_d;
      proto_q   <= proto_d;
    end
  end

  // Strobe and ack both decode the ISSUE state so they are always coincident
  assign ddr_cmd_en = (state_q == ARB_ISSUE);

  // Per-requester ack decode and saturating wait counter with sticky flag
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              starve_q, starve_d;

    assign ack[g] = ddr_cmd_en && (win_idx_q == IDX_W'(g));

    always_comb begin
      wait_d   = '0;
      starve_d = starve_q;
      if (req[g] && !ack[g]) begin
        wait_d = (wait_q == WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + WAIT_W'(1);
      end
      if (wait_d == WAIT_W'(MAX_WAIT)) starve_d = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge _reset) begin
      if (!_reset) begin
        wait_q   <= '0;
        starve_q <= 1'b0;
      end else begin
        wait_q   <= wait_d;
        starve_q <= starve_d;
      end
    end

    assign starve_err[g] = starve_q;
  end

  assign ddr_cmd_clk       = sys_clk;
  assign ddr_cmd_instr     = cmd_q.instr;
  assign ddr_cmd_bl        = cmd_q.bl;
  assign ddr_cmd_byte_addr = cmd_q.byte_addr;
  assign busy              = (state_q != ARB_IDLE) || !ddr_cmd_empty;
  assign proto_err         = proto_q;

endmodule

// File: tb/tb_fcl_ddr_cmd_arb.sv
// Self-checking bench for fcl_ddr_cmd_arb: directed scenarios followed by
// randomized requesters, all checked against a cycle-timing reference model.
module tb_fcl_ddr_cmd_arb;
  import fcl_ddr_pkg::*;

  localparam int N  = 2;
  localparam int MW = 16;

  logic          sys_clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [3*N-1:0]  req_instr;
  logic [6*N-1:0]  req_bl;
  logic [30*N-1:0] req_byte_addr;
  logic [N-1:0]  ack;
  logic          ddr_cmd_clk;
  logic          ddr_cmd_en;
  logic [2:0]    ddr_cmd_instr;
  logic [5:0]    ddr_cmd_bl;
  logic [29:0]   ddr_cmd_byte_addr;
  logic          ddr_cmd_full;
  logic          ddr_cmd_empty;
  logic          busy;
  logic [N-1:0]  starve_err;
  logic          proto_err;

  fcl_ddr_cmd_arb #(.NUM_REQ(N), .MAX_WAIT(MW)) dut (
    .sys_clk           (sys_clk),
    ._reset            (rst_n),
    .req               (req),
    .req_instr         (req_instr),
    .req_bl            (req_bl),
    .req_byte_addr     (req_byte_addr),
    .ack               (ack),
    .ddr_cmd_clk       (ddr_cmd_clk),
    .ddr_cmd_en        (ddr_cmd_en),
    .ddr_cmd_instr     (ddr_cmd_instr),
    .ddr_cmd_bl        (ddr_cmd_bl),
    .ddr_cmd_byte_addr (ddr_cmd_byte_addr),
    .ddr_cmd_full      (ddr_cmd_full),
    .ddr_cmd_empty     (ddr_cmd_empty),
    .busy              (busy),
    .starve_err        (starve_err),
    .proto_err         (proto_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: timing expressed as edge numbers. A selection at edge ks
  // makes the following cycle the command cycle; the next selection can only
  // happen at edge ks+3 or later.
  int          k;
  int          ks;
  int          m_win;
  int          m_rr;
  logic [2:0]  m_instr;
  logic [5:0]  m_bl;
  logic [29:0] m_addr;
  int          m_wait [N];
  logic [N-1:0] m_starve;
  logic        m_proto;
  logic [N-1:0] ack_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; ks = -100; m_win = 0; m_rr = 0;
    m_instr = '0; m_bl = '0; m_addr = '0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    m_starve = '0; m_proto = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic f);
    logic ack_cycle;
    int idx;
    k++;
    ack_cycle = (k == ks + 1);
    for (int i = 0; i < N; i++) begin
      if (r[i] && !(ack_cycle && m_win == i)) m_wait[i] = (m_wait[i] >= MW) ? MW : m_wait[i] + 1;
      else m_wait[i] = 0;
      if (m_wait[i] == MW) m_starve[i] = 1'b1;
    end
    if (ack_cycle) begin
      if (!r[m_win]) m_proto = 1'b1;
      m_rr = (m_win + 1) % N;
    end
    if (k >= ks + 3 && r != '0 && !f) begin
      for (int j = N - 1; j >= 0; j--) begin
        idx = (m_rr + j) % N;
        if (r[idx]) m_win = idx;
      end
      ks = k;
      m_instr = req_instr[3*m_win +: 3];
      m_bl    = req_bl[6*m_win +: 6];
      m_addr  = req_byte_addr[30*m_win +: 30];
    end
  endtask

  task automatic check_all();
    logic en_e;
    logic [N-1:0] ack_e;
    en_e  = (k == ks);
    ack_e = en_e ? N'(1) << m_win : '0;
    chk("cmd_en", 64'(ddr_cmd_en), 64'(en_e));
    chk("ack", 64'(ack), 64'(ack_e));
    chk("instr", 64'(ddr_cmd_instr), 64'(m_instr));
    chk("bl", 64'(ddr_cmd_bl), 64'(m_bl));
    chk("byte_addr", 64'(ddr_cmd_byte_addr), 64'(m_addr));
    chk("busy", 64'(busy), 64'((k == ks) || (k == ks + 1) || !ddr_cmd_empty));
    chk("starve_err", 64'(starve_err), 64'(m_starve));
    chk("proto_err", 64'(proto_err), 64'(m_proto));
    chk("cmd_clk", 64'(ddr_cmd_clk), 64'(1));
  endtask

  task automatic step();
    logic [N-1:0] r;
    logic f;
    @(posedge sys_clk);
    r = req; f = ddr_cmd_full;
    if (!rst_n) model_reset();
    else model_edge(r, f);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cmd(input int i, input logic [2:0] ins, input logic [5:0] bl, input logic [29:0] a);
    req_instr[3*i +: 3]      = ins;
    req_bl[6*i +: 6]         = bl;
    req_byte_addr[30*i +: 30] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; ddr_cmd_full = 1'b0; ddr_cmd_empty = 1'b1;
    ack_seen = '0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Randomized requester: holds req through its ack cycle, then changes
  task automatic agents();
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i]) begin
        ack_seen[i] = 1'b0;
        req[i] = 1'($urandom_range(0, 1));
        set_cmd(i, 3'($urandom_range(0, 4)), 6'($urandom), 30'($urandom));
      end else if (ack[i]) begin
        ack_seen[i] = 1'b1;
      end else if (!req[i] && $urandom_range(0, 2) == 0) begin
        req[i] = 1'b1;
        set_cmd(i, 3'($urandom_range(0, 4)), 6'($urandom), 30'($urandom));
      end
    end
    ddr_cmd_full  = ($urandom_range(0, 3) == 0);
    ddr_cmd_empty = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst_n = 1'b1;
    req = '0; req_instr = '0; req_bl = '0; req_byte_addr = '0;
    ddr_cmd_full = 1'b0; ddr_cmd_empty = 1'b1; ack_seen = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_en", 64'(ddr_cmd_en), 64'(0));
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_addr", 64'(ddr_cmd_byte_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_errs", 64'({starve_err, proto_err}), 64'(0));
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Single requester: granted every third cycle
    set_cmd(0, MCB_WR, 6'd63, 30'h100);
    req = 2'b01;
    step();
    chk("single_ack", 64'(ack), 64'(2'b01));
    chk("single_addr", 64'(ddr_cmd_byte_addr), 64'(30'h100));
    chk("single_bl", 64'(ddr_cmd_bl), 64'(63));
    steps(2);
    chk("single_gap", 64'(ddr_cmd_en), 64'(0));
    step();
    chk("single_regrant", 64'(ack), 64'(2'b01));
    step();
    req = 2'b00;
    steps(3);

    // Both requesting continuously: grants alternate
    do_reset();
    set_cmd(0, MCB_RD, 6'd15, 30'h2000);
    set_cmd(1, MCB_WR_AP, 6'd31, 30'h3abc0);
    req = 2'b11;
    step();
    chk("alt_first", 64'(ack), 64'(2'b01));
    steps(3);
    chk("alt_second", 64'(ack), 64'(2'b10));
    chk("alt_second_addr", 64'(ddr_cmd_byte_addr), 64'(30'h3abc0));
    steps(3);
    chk("alt_third", 64'(ack), 64'(2'b01));
    steps(3);
    chk("alt_fourth", 64'(ack), 64'(2'b10));
    step();
    req = 2'b00;
    steps(2);

    // Command FIFO full blocks all grants
    do_reset();
    set_cmd(0, MCB_RD_AP, 6'd7, 30'h40);
    set_cmd(1, MCB_REFRESH, 6'd0, 30'h80);
    ddr_cmd_full = 1'b1;
    req = 2'b11;
    steps(20);
    chk("full_no_en", 64'(ddr_cmd_en), 64'(0));
    ddr_cmd_full = 1'b0;
    step();
    chk("full_release_ack", 64'(ack), 64'(2'b01));
    step();
    req = 2'b10;
    steps(2);
    chk("full_next_ack", 64'(ack), 64'(2'b10));
    step();
    req = 2'b00;
    steps(2);

    // Starvation flag at exactly MAX_WAIT pending cycles, sticky afterwards
    do_reset();
    ddr_cmd_full = 1'b1;
    req = 2'b10;
    steps(MW - 1);
    chk("starve_before", 64'(starve_err), 64'(2'b00));
    step();
    chk("starve_at", 64'(starve_err), 64'(2'b10));
    ddr_cmd_full = 1'b0;
    step();
    chk("starve_grant", 64'(ack), 64'(2'b10));
    step();
    req = 2'b00;
    steps(3);
    chk("starve_sticky", 64'(starve_err), 64'(2'b10));

    // Winner dropping req during its command cycle
    do_reset();
    set_cmd(1, MCB_WR, 6'd3, 30'h555);
    req = 2'b10;
    step();
    chk("proto_en", 64'(ddr_cmd_en), 64'(1));
    req = 2'b00;
    step();
    chk("proto_set", 64'(proto_err), 64'(1));
    steps(3);

    // Async reset in the middle of a command cycle
    do_reset();
    set_cmd(0, MCB_RD, 6'd9, 30'h1234);
    set_cmd(1, MCB_RD, 6'd10, 30'h5678);
    req = 2'b11;
    steps(4);
    chk("midrst_pre_ack", 64'(ack), 64'(2'b10));
    rst_n = 1'b0;
    #1;
    chk("midrst_en", 64'(ddr_cmd_en), 64'(0));
    chk("midrst_ack", 64'(ack), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_addr", 64'(ddr_cmd_byte_addr), 64'(0));
    model_reset();
    @(negedge sys_clk);
    rst_n = 1'b1;
    step();
    chk("midrst_next_ack", 64'(ack), 64'(2'b01));
    step();
    req = 2'b00;
    steps(2);

    // Randomized requesters against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      agents();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
